mem_stream_reader: RTL

//  Request-side initiator for the dual-port dataflow memory interface. One port's

---
 rtl/mem_stream_reader.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/mem_stream_reader.sv
`default_nettype none
// ============================================================================
// Module      : mem_stream_reader
// Description : Read-request initiator for one port of the dual-port dataflow
//               memory interface. Issues COUNT reads at base + i*stride,
//               bounds outstanding reads with credits, returns the data in
//               order on a stop-backpressured stream and then pulses done.
// Options     : MEM_STREAM_READER_CHECKSUM_EN adds a running checksum output.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stream_reader #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 4,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base,
    input  logic [ADDR_W-1:0] stride,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] addr,
    input  logic              addr_stop,
    output logic [DATA_W-1:0] wdata,
    input  logic              wdata_stop,
    output logic [1:0]        wren,
    input  logic              wren_stop,
    output logic              req_valid,
    input  logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_valid,
    output logic              rsp_stop,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    input  logic              dout_stop
`ifdef MEM_STREAM_READER_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    localparam int PTR_W = $clog2(MAX_OUT);
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_MAX = OCC_W'(MAX_OUT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [ADDR_W-1:0]  stride_q;
    logic [CNT_W-1:0]   remaining;
    logic [OCC_W-1:0]   inflight;
    logic [OCC_W-1:0]   occ;
    logic [DATA_W-1:0]  mem [MAX_OUT];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;

    logic start_ok;
    logic has_credit;
    logic can_issue;
    logic issue;
    logic rsp_write;
    logic pop;

    // Request, response and pop handshakes. The shared request valid is
    // withheld while any channel stalls so all three channels move together.
    assign start_ok   = (state == S_IDLE) && start;
    assign has_credit = (inflight + occ) < OCC_MAX;
    assign can_issue  = (state == S_ISSUE) && (remaining != '0) && has_credit;
    assign req_valid  = can_issue && !addr_stop && !wdata_stop && !wren_stop;
    assign issue      = req_valid;
    assign wdata      = '0;
    assign wren       = 2'b00;

    // Responses with nothing outstanding (e.g. after a reset) are absorbed.
    assign rsp_stop   = (occ == OCC_MAX);
    assign rsp_write  = rsp_valid && !rsp_stop && (inflight != '0);

    assign dout_valid = (occ != '0);
    assign dout       = dout_valid ? mem[rd_ptr] : '0;
    assign pop        = dout_valid && !dout_stop;

    assign busy       = (state == S_ISSUE) || (state == S_DRAIN);
    assign done       = (state == S_DONE);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = (count != '0) ? S_ISSUE : S_DONE;
                end
            end
            S_ISSUE: begin
                if (issue && (remaining == CNT_W'(1))) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((inflight == '0) && (occ == OCC_W'(1)) && pop) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address generator and remaining-read counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr      <= '0;
            stride_q  <= '0;
            remaining <= '0;
        end else if (start_ok) begin
            addr      <= base;
            stride_q  <= stride;
            remaining <= count;
        end else if (issue) begin
            addr      <= addr + stride_q;
            remaining <= remaining - CNT_W'(1);
        end
    end

    // Credit bookkeeping: issue, response and pop may coincide in one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
            occ      <= '0;
        end else begin
            inflight <= inflight + OCC_W'(issue) - OCC_W'(rsp_write);
            occ      <= occ + OCC_W'(rsp_write) - OCC_W'(pop);
        end
    end

    // Return FIFO storage and pointers (first-word-fall-through)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_OUT; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (rsp_write) begin
                mem[wr_ptr] <= rsp_data;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
        end
    end

`ifdef MEM_STREAM_READER_CHECKSUM_EN
    // Running sum of delivered words; cleared on an accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (pop) begin
            checksum <= checksum + dout;
        end
    end
`endif

endmodule
`default_nettype wire
